// File: rtl/bus_mem_responder.sv
// Main-memory endpoint for the 64-bit request/response bus: serves 8-beat block reads
// after a fixed latency and absorbs 8-beat block write bursts into a word-addressed store.
module bus_mem_responder #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned DEPTH_BLOCKS   = 1024,
  parameter int unsigned LATENCY        = 4,
  parameter int unsigned READ_TAG_BIT   = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack,
  output logic                      busy
);

  localparam int unsigned BLK_W    = $clog2(DEPTH_BLOCKS);
  localparam int unsigned BEAT_W   = 3;
  localparam int unsigned IDX_W    = BLK_W + BEAT_W;
  localparam int unsigned WORDS    = DEPTH_BLOCKS * 8;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned ADDR_LSB = 6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_WAIT  = 2'd1,
    ST_RD_BURST = 2'd2,
    ST_WR_DATA  = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [BLK_W-1:0]          blk_q, blk_d;
  logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic                      reqack_q, reqack_d;
  logic                      respcyc_q, respcyc_d;
  logic [BUS_DATA_WIDTH-1:0] resp_q, resp_d;
  logic [BUS_TAG_WIDTH-1:0]  resptag_q, resptag_d;
  logic                      busy_q, busy_d;

  logic [BUS_DATA_WIDTH-1:0] mem_q [WORDS];

  logic                      accept_c;
  logic                      resp_fire_c;
  logic                      is_read_c;
  logic                      last_beat_c;
  logic [BEAT_W-1:0]         beat_nxt_c;
  logic [IDX_W-1:0]          mem_ridx_c;
  logic [IDX_W-1:0]          mem_widx_c;
  logic [BUS_DATA_WIDTH-1:0] mem_rdata_c;
  logic                      mem_we_c;

  assign accept_c    = bus_reqcyc & reqack_q;
  assign resp_fire_c = respcyc_q & bus_respack;
  assign is_read_c   = bus_reqtag[READ_TAG_BIT];
  assign last_beat_c = (beat_q == BEAT_W'(7));
  assign beat_nxt_c  = beat_q + BEAT_W'(1);

  // Read port looks one beat ahead so the next word is ready when the current one is taken.
  assign mem_ridx_c  = (state_q == ST_RD_BURST) ? {blk_q, beat_nxt_c} : {blk_q, BEAT_W'(0)};
  assign mem_widx_c  = {blk_q, beat_q};
  assign mem_rdata_c = mem_q[mem_ridx_c];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = is_read_c ? ST_RD_WAIT : ST_WR_DATA;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RD_BURST;
        end
      end
      ST_RD_BURST: begin
        if (resp_fire_c && last_beat_c) begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_DATA: begin
        if (accept_c && last_beat_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; handshake flags follow the state being entered
  always_comb begin
    blk_d     = blk_q;
    tag_d     = tag_q;
    cnt_d     = cnt_q;
    beat_d    = beat_q;
    resp_d    = resp_q;
    resptag_d = resptag_q;
    mem_we_c  = 1'b0;
    reqack_d  = (state_d == ST_IDLE) || (state_d == ST_WR_DATA);
    respcyc_d = (state_d == ST_RD_BURST);
    busy_d    = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          blk_d  = bus_req[ADDR_LSB +: BLK_W];
          tag_d  = bus_reqtag;
          beat_d = '0;
          cnt_d  = is_read_c ? CNT_W'(LATENCY - 1) : '0;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == '0) begin
          beat_d    = '0;
          resp_d    = mem_rdata_c;
          resptag_d = tag_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RD_BURST: begin
        if (resp_fire_c) begin
          if (last_beat_c) begin
            beat_d = '0;
          end else begin
            beat_d = beat_nxt_c;
            resp_d = mem_rdata_c;
          end
        end
      end
      ST_WR_DATA: begin
        if (accept_c) begin
          mem_we_c = 1'b1;
          beat_d   = beat_nxt_c;
        end
      end
      default: begin
        beat_d = '0;
      end
    endcase
  end

  // Registered outputs and transaction context
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blk_q     <= '0;
      tag_q     <= '0;
      cnt_q     <= '0;
      beat_q    <= '0;
      reqack_q  <= 1'b0;
      respcyc_q <= 1'b0;
      resp_q    <= '0;
      resptag_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      blk_q     <= blk_d;
      tag_q     <= tag_d;
      cnt_q     <= cnt_d;
      beat_q    <= beat_d;
      reqack_q  <= reqack_d;
      respcyc_q <= respcyc_d;
      resp_q    <= resp_d;
      resptag_q <= resptag_d;
      busy_q    <= busy_d;
    end
  end

  // Backing store is deliberately not reset; written beats survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[mem_widx_c] <= bus_req;
    end
  end

  assign bus_reqack  = reqack_q;
  assign bus_respcyc = respcyc_q;
  assign bus_resp    = resp_q;
  assign bus_resptag = resptag_q;
  assign busy        = busy_q;

endmodule

// File: doc/bus_mem_responder.md
# bus_mem_responder

Memory-side responder for the shared 64-bit request/response bus that the cache's block-fill and block-flush engines drive. Accepts block read and block write requests, holds a parameterized word-addressed backing store, returns 64-byte blocks as 8 tagged response beats, and absorbs 8-beat write bursts. Sits at the far end of the bus arbiter; serves as the main-memory endpoint in cache and pipeline simulations.

## Interface
- BUS_DATA_WIDTH, 64, data/address beat width; only 64 is supported
- BUS_TAG_WIDTH, 13, request/response tag width
- DEPTH_BLOCKS, 1024, number of 64-byte blocks in the backing store; power of two
- LATENCY, 4, cycles from read-request acceptance to the first response beat; legal range 1..255
- READ_TAG_BIT, 12, bit of `bus_reqtag` that selects the operation: 1 = read, 0 = write

- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset; asserting it forces every output to its reset value immediately
- bus_reqcyc  in  1  initiator request/data beat valid
- bus_req  in  BUS_DATA_WIDTH  address beat (first beat) or write data beat
- bus_reqtag  in  BUS_TAG_WIDTH  request tag, sampled on the address beat only
- bus_reqack  out  1  responder ready; a beat transfers on an edge where `bus_reqcyc` and `bus_reqack` are both 1
- bus_respcyc  out  1  response beat valid
- bus_resp  out  BUS_DATA_WIDTH  read response data
- bus_resptag  out  BUS_TAG_WIDTH  tag latched from the accepted read request
- bus_respack  in  1  initiator accepts the current response beat
- busy  out  1  1 in every state except IDLE

## Operation
- States: IDLE, RD_WAIT, RD_BURST, WR_DATA.
- Storage: 64-bit words, DEPTH_BLOCKS*8 entries, not reset. Word index = {block, beat}. Block = addr[6+log2(DEPTH_BLOCKS)-1:6]. Upper address bits are ignored, so out-of-range addresses wrap modulo capacity. addr[5:0] are ignored, so every request is block-aligned.
- IDLE: `bus_reqack`=1. On an accepted beat, latch the block index and `bus_reqtag`, then dispatch on `bus_reqtag[READ_TAG_BIT]`:
  - 1: clear `bus_reqack`, load the latency counter with LATENCY-1, go to RD_WAIT.
  - 0: go to WR_DATA with beat counter = 0 and `bus_reqack` held at 1.
- RD_WAIT: decrement the counter. At 0, go to RD_BURST with beat = 0 and drive `bus_respcyc`=1, `bus_resp`=mem[block,0], `bus_resptag`=latched tag.
- RD_BURST: hold the current beat until `bus_respack`=1 at an edge, then present the next beat in the following cycle. Beats go in order 0..7.
  - After beat 7 is accepted: `bus_respcyc`=0, `bus_reqack`=1, go to IDLE.
  - `bus_reqcyc` is ignored while not in IDLE or WR_DATA.
- WR_DATA: each accepted beat writes `bus_req` to mem[block,beat] and increments beat (3-bit). The beat-7 transfer returns the block to IDLE with `bus_reqack` remaining 1. Write bursts produce no response beats.
- Reset values: `bus_reqack`=0, `bus_respcyc`=0, `bus_resp`=0, `bus_resptag`=0, `busy`=0, state IDLE, counters 0. The first edge after reset is released sets `bus_reqack`=1.
- Reset mid-burst: the transaction is abandoned. Write beats already written remain in memory. No partial response resumes.
- All outputs are registered.

## Timing
- Read: address accepted at edge E0. `bus_respcyc` rises after edge E0+LATENCY. With `bus_respack` tied to 1, beats 0..7 occupy 8 consecutive cycles. `bus_reqack` returns to 1 after the edge that accepts beat 7. Minimum read occupancy is LATENCY+8 cycles.
- Write: 9 transfers (1 address + 8 data). With `bus_reqcyc` held at 1, the burst completes in 9 consecutive edges. A new request can be accepted on the very next edge.
- `bus_respack` while `bus_respcyc`=0 is ignored.
- `bus_resp`/`bus_resptag` are stable while `bus_respcyc`=1 and `bus_respack`=0.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with `bus_reqcyc`=1 -> all outputs 0 throughout. `bus_reqack`=1 one edge after release. No transaction starts before that.
- Write then read: write tag 0x0005 at address 0x1000 with data 0x1111..0x8888. Then read tag 0x1005 at 0x1000 with LATENCY=4 and `bus_respack`=1 -> first `bus_respcyc` 4 cycles after acceptance, 8 beats 0x1111..0x8888 in order, `bus_resptag`=0x1005 on every beat.
- Backpressure: same read with `bus_respack` low for 3 cycles on beat 2 -> beat 2 held stable for 4 cycles, no beat skipped or duplicated, 11 valid cycles total.
- Busy rejection: assert a second read request during RD_WAIT and RD_BURST -> `bus_reqack`=0 and the request is not accepted until after beat 7. It is then accepted in the following cycle and returns its own tag.
- Wrap/alignment (DEPTH_BLOCKS=1024): write to 0x1003F, read from 0x10000 and from 0x0 -> both reads return the written data.
- Reset mid-read at beat 3 -> `bus_respcyc` drops immediately. After release, a new read returns a complete 8-beat block.
